// File: rtl/comm_rx.sv
// 8N1 serial receiver for the j1soc comm link: synchronizer, bit-sampling FSM
// and a small circular byte FIFO with valid/ready pop.
module comm_rx #(
   parameter int unsigned CLK_DIV    = 434,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       sys_clk_i,
   input  logic       sys_rst_i,
   input  logic       c_tx,
   input  logic       c_bussy,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       rx_busy,
   output logic       link_active
);

   localparam int unsigned BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam logic [BW-1:0] BAUD_FULL = BW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BAUD_HALF = BW'(CLK_DIV / 2 - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   state_e        state_q, state_d;
   logic          sync1_q, sync2_q, prev_q;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic          fe_q, fe_d, ov_q, ov_d, link_q;
   logic [7:0]    mem_q [FIFO_DEPTH];

   logic push, push_ok, pop, empty, full;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      push    = 1'b0;
      fe_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (prev_q && !sync2_q) begin
               state_d = START;
               bit_d   = '0;
               baud_d  = BAUD_HALF;
            end
         end
         START: begin
            if (baud_q == '0) begin
               if (!sync2_q) begin
                  state_d = DATA;
                  baud_d  = BAUD_FULL;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end
         DATA: begin
            if (baud_q == '0) begin
               shift_d = {sync2_q, shift_q[7:1]};
               baud_d  = BAUD_FULL;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = STOP;
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end
         STOP: begin
            if (baud_q == '0) begin
               state_d = IDLE;
               if (sync2_q) push = 1'b1;
               else         fe_d = 1'b1;
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Full when pointers alias on the index bits but differ in the wrap bit.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop     = rx_ready && !empty;
   assign push_ok = push && (!full || pop);
   assign ov_d    = push && full && !pop;
   assign wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
   assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop);

   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         state_q  <= IDLE;
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         prev_q   <= 1'b1;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fe_q     <= 1'b0;
         ov_q     <= 1'b0;
         link_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync1_q  <= c_tx;
         sync2_q  <= sync1_q;
         prev_q   <= sync2_q;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fe_q     <= fe_d;
         ov_q     <= ov_d;
         link_q   <= c_bussy || (state_q != IDLE);
      end
   end

   always_ff @(posedge sys_clk_i) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
   end

   assign rx_data     = mem_q[rd_ptr_q[AW-1:0]];
   assign rx_valid    = !empty;
   assign frame_err   = fe_q;
   assign overrun     = ov_q;
   assign rx_busy     = (state_q != IDLE);
   assign link_active = link_q;

endmodule

// File: tb/tb_comm_rx.sv
// Directed bench for comm_rx at CLK_DIV=8: table of single frames plus
// hand sequences for glitch, overrun, pop-at-full and mid-frame reset.
module tb_comm_rx;
   localparam int unsigned CLK_DIV    = 8;
   localparam int unsigned FIFO_DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       c_tx = 1'b1;
   logic       c_bussy = 1'b0;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, overrun, rx_busy, link_active;

   always #5 clk = ~clk;

   comm_rx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .sys_clk_i  (clk),
      .sys_rst_i  (rst),
      .c_tx       (c_tx),
      .c_bussy    (c_bussy),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .rx_busy    (rx_busy),
      .link_active(link_active)
   );

   typedef struct {
      logic [7:0] data;
      logic       stopb;
      logic       exp_valid;
      int         exp_fe;
   } vec_t;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   fe_cnt = 0;
   int   ov_cnt = 0;
   int   rise_cyc = -1;
   int   start_cyc = 0;
   logic valid_prev = 1'b0;
   logic pop_at_stop = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (rx_valid && !valid_prev) rise_cyc = cyc;
      valid_prev = rx_valid;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      @(posedge clk); #1 c_tx = b;
      repeat (7) @(posedge clk);
   endtask

   // Returns just after the edge on which the stop bit is sampled.
   task automatic send(input logic [7:0] d, input logic stopb);
      @(posedge clk); #1 c_tx = 1'b0;
      start_cyc = cyc;
      repeat (7) @(posedge clk);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      @(posedge clk); #1 c_tx = stopb;
      if (pop_at_stop) begin
         repeat (6) @(posedge clk);
         #1 rx_ready = 1'b1;
         @(posedge clk); #1 rx_ready = 1'b0;
      end else begin
         repeat (7) @(posedge clk);
      end
   endtask

   task automatic idle(input int n);
      @(posedge clk); #1 c_tx = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pop_one();
      rx_ready = 1'b1;
      @(posedge clk); #1 rx_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t vecs[6];
      int   fe0, ov0;
      logic [7:0] abort_byte;
      vecs[0] = '{8'hA5, 1'b1, 1'b1, 0};
      vecs[1] = '{8'h00, 1'b1, 1'b1, 0};
      vecs[2] = '{8'hFF, 1'b1, 1'b1, 0};
      vecs[3] = '{8'h3C, 1'b0, 1'b0, 1};
      vecs[4] = '{8'h81, 1'b1, 1'b1, 0};
      vecs[5] = '{8'h5A, 1'b0, 1'b0, 1};

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", rx_valid, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_busy", rx_busy, 0);
      chk("rst_link", link_active, 0);
      rst = 1'b0;

      c_bussy = 1'b1;
      @(posedge clk); #1 chk("link_bussy_hi", link_active, 1);
      c_bussy = 1'b0;
      @(posedge clk); #1 chk("link_bussy_lo", link_active, 0);

      // Streaming consumer: byte appears for exactly one cycle.
      rx_ready = 1'b1;
      send(8'hA5, 1'b1);
      @(negedge clk);
      chk("a5_valid", rx_valid, 1);
      chk("a5_data", rx_data, 8'hA5);
      chk("a5_busy_done", rx_busy, 0);
      chk("a5_no_fe", frame_err, 0);
      @(negedge clk);
      chk("a5_valid_one_cycle", rx_valid, 0);
      chk("a5_latency", rise_cyc - start_cyc, 79);
      idle(4);
      rx_ready = 1'b0;

      fe0 = fe_cnt; ov0 = ov_cnt;
      @(posedge clk); #1 c_tx = 1'b0;
      repeat (3) @(posedge clk);
      #1 c_tx = 1'b1;
      chk("glitch_busy_start", rx_busy, 1);
      repeat (20) @(posedge clk);
      #1;
      chk("glitch_busy_end", rx_busy, 0);
      chk("glitch_valid", rx_valid, 0);
      chk("glitch_fe", fe_cnt - fe0, 0);
      chk("glitch_ov", ov_cnt - ov0, 0);

      rx_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1 rx_ready = 1'b0;
      chk("pop_empty_valid", rx_valid, 0);

      for (int v = 0; v < 6; v++) begin
         fe0 = fe_cnt;
         send(vecs[v].data, vecs[v].stopb);
         @(negedge clk);
         chk("vec_valid", rx_valid, vecs[v].exp_valid);
         if (vecs[v].exp_valid) chk("vec_data", rx_data, vecs[v].data);
         idle(4);
         chk("vec_fe_count", fe_cnt - fe0, vecs[v].exp_fe);
         chk("vec_busy", rx_busy, 0);
         pop_one();
         chk("vec_drained", rx_valid, 0);
      end

      ov0 = ov_cnt;
      for (int b = 1; b <= 4; b++) begin
         send(8'(b), 1'b1);
         idle(4);
      end
      chk("fill_no_ov", ov_cnt - ov0, 0);
      send(8'h05, 1'b1);
      idle(4);
      chk("full_ov_once", ov_cnt - ov0, 1);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("ovr_valid", rx_valid, 1);
         chk("ovr_data", rx_data, 8'(k));
         pop_one();
      end
      @(negedge clk);
      chk("ovr_empty", rx_valid, 0);

      ov0 = ov_cnt;
      for (int b = 1; b <= 4; b++) begin
         send(8'(b), 1'b1);
         idle(4);
      end
      pop_at_stop = 1'b1;
      send(8'h05, 1'b1);
      pop_at_stop = 1'b0;
      idle(4);
      chk("popfull_no_ov", ov_cnt - ov0, 0);
      for (int k = 2; k <= 5; k++) begin
         @(negedge clk);
         chk("popfull_valid", rx_valid, 1);
         chk("popfull_data", rx_data, 8'(k));
         pop_one();
      end
      @(negedge clk);
      chk("popfull_empty", rx_valid, 0);

      send(8'h11, 1'b1); idle(4);
      send(8'h22, 1'b1); idle(4);
      chk("pre_rst_valid", rx_valid, 1);
      abort_byte = 8'h96;
      @(posedge clk); #1 c_tx = 1'b0;
      repeat (7) @(posedge clk);
      for (int i = 0; i < 4; i++) drive_bit(abort_byte[i]);
      @(posedge clk); #1 c_tx = abort_byte[4];
      repeat (3) @(posedge clk);
      #1 chk("mid_busy", rx_busy, 1);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      c_tx = 1'b1;
      chk("mid_rst_valid", rx_valid, 0);
      chk("mid_rst_busy", rx_busy, 0);
      repeat (10) @(posedge clk);
      send(8'h7E, 1'b1);
      @(negedge clk);
      chk("after_rst_valid", rx_valid, 1);
      chk("after_rst_data", rx_data, 8'h7E);
      idle(2);
      chk("after_rst_latency", rise_cyc - start_cyc, 79);
      pop_one();
      chk("after_rst_drained", rx_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/comm_rx.md
COMM_RX -- requirements
Module: comm_rx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 434, meaning sys_clk_i cycles per serial bit (50 MHz / 115200).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning received-byte buffer entries (power of two, min 2).
REQ-003 SHALL have port sys_clk_i  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port c_tx  input  1  serial line from the j1soc communications transmitter; idle high, 8N1, LSB first.
REQ-006 SHALL have port c_bussy  input  1  transmitter busy flag; used only for status, never gates reception.
REQ-007 SHALL have port rx_data  output  8  byte at FIFO head.
REQ-008 SHALL have port rx_valid  output  1  FIFO non-empty; rx_data is valid.
REQ-009 SHALL have port rx_ready  input  1  consumer pops the head byte when rx_valid && rx_ready.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-011 SHALL have port overrun  output  1  one-cycle pulse when a good byte arrives with the FIFO full.
REQ-012 SHALL have port rx_busy  output  1  high while the FSM is not IDLE.
REQ-013 SHALL have port link_active  output  1  registered copy of c_bussy OR rx_busy.

Function
REQ-014 SHALL pass c_tx through a two-flop synchronizer preset to 1; all sampling uses the second flop (2-cycle input latency).
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-016 IDLE: SHALL go to START on a synchronized falling edge (previous 1, current 0); bit counter cleared, baud counter loaded.
REQ-017 START: SHALL wait CLK_DIV/2 cycles (integer division), then sample; if 0 go to DATA, if 1 (glitch) go to IDLE with no other effect.
REQ-018 DATA: SHALL sample every CLK_DIV cycles, shifting into bit 7 of a shift register (LSB first); after 8th sample go to STOP.
REQ-019 STOP: SHALL sample after CLK_DIV cycles; if 1 push byte into FIFO; if 0 pulse frame_err and discard byte; always go to IDLE.
REQ-020 Baud counter SHALL be $clog2(CLK_DIV) bits, count down to 0, reload CLK_DIV-1; no wrap beyond reload.
REQ-021 rx_valid SHALL assert the cycle after the stop-bit sample when the FIFO was empty.
REQ-022 FIFO SHALL be circular with read/write pointers of log2(FIFO_DEPTH)+1 bits; full when MSBs differ and LSBs equal.
REQ-023 Push with FIFO full and no simultaneous pop SHALL drop the new byte, pulse overrun, leave contents unchanged.
REQ-024 Simultaneous push and pop when full SHALL both succeed; no overrun.
REQ-025 Simultaneous push and pop when empty SHALL store the byte; rx_valid high next cycle.
REQ-026 Pop when empty SHALL be ignored; pointers unchanged.
REQ-027 rx_data SHALL show the head entry combinationally from FIFO memory; value undefined when rx_valid low.
REQ-028 A falling edge during START/DATA/STOP SHALL not restart the frame.

Reset
REQ-029 On sys_rst_i high at a clock edge: FSM IDLE, pointers 0, rx_valid 0, frame_err 0, overrun 0, rx_busy 0, link_active 0, synchronizer 1, shift register 0x00.
REQ-030 Reset mid-frame SHALL abandon the frame and discard all FIFO contents; reception resumes on the next falling edge after release.

Verification (CLK_DIV=8)
REQ-031 Send 0xA5 8N1, rx_ready=1 -> rx_valid one cycle, rx_data=0xA5, frame_err=0, rx_busy low after STOP.
REQ-032 Drive c_tx low 3 cycles then high -> START aborts, rx_valid stays 0, no error pulses.
REQ-033 Send 0x3C with stop bit 0 -> frame_err pulses once, rx_valid stays 0.
REQ-034 Send 0x01..0x05 with rx_ready=0 -> rx_valid=1, overrun pulses once at 5th byte; pops return 0x01,0x02,0x03,0x04, then rx_valid=0.
REQ-035 Assert sys_rst_i during DATA bit 4 with 2 bytes buffered -> rx_valid=0, rx_busy=0; next byte 0x7E received correctly.
REQ-036 Pop on same cycle 5th byte lands with FIFO full -> no overrun; bytes 0x02..0x05 read in order.
